// File: rtl/fifo_rr_arbiter_pkg.sv
// Shared types for the round-robin FIFO arbiter: output-channel state and
// counter width.
package fifo_rr_arbiter_pkg;

    localparam int TX_COUNT_W = 16;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } arb_state_e;

endpackage

// File: rtl/fifo_rr_arbiter_rr_select.sv
// Rotating-priority selector: a double-width masked priority encoder that
// returns the first requester after `last`, wrapping modulo N.
module rr_select #(
    parameter int N      = 4,
    parameter int N_LOG2 = 2
) (
    input  logic [N-1:0]      req,
    input  logic [N_LOG2-1:0] last,
    output logic [N-1:0]      grant,
    output logic [N_LOG2-1:0] grant_idx,
    output logic              any_req
);

    logic [N-1:0]   masked_s;
    logic [2*N-1:0] dbl_s;
    logic           found_s;

    // Upper half is the raw request vector, lower half keeps only indices above last.
    always_comb begin
        masked_s = '0;
        for (int i = 0; i < N; i++) begin
            masked_s[i] = req[i] & (i > int'(last));
        end
        dbl_s   = {req, masked_s};
        any_req = |req;
    end

    // Lowest set bit of the doubled vector, folded back into 0..N-1.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found_s   = 1'b0;
        for (int i = 0; i < 2 * N; i++) begin
            if (!found_s && dbl_s[i]) begin
                found_s          = 1'b1;
                grant_idx        = N_LOG2'(i % N);
                grant[i % N]     = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter popping N input FIFOs onto one registered
// valid/ready output channel, sustaining one item per cycle.
import fifo_rr_arbiter_pkg::*;

module fifo_rr_arbiter #(
    parameter int ID               = -1,
    parameter int SIZE             = 8,
    parameter int N                = 4,
    parameter int N_LOG2           = 2,
    parameter int DESTINATION_BITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N-1:0]          fifo_empty,
    input  logic [N*SIZE-1:0]     fifo_item,
    output logic [N-1:0]          fifo_read,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SIZE-1:0]       out_item,
    output logic [N_LOG2-1:0]     out_src,
    output logic [TX_COUNT_W-1:0] tx_count
);

    if (N < 2 || (2 ** N_LOG2) < N || DESTINATION_BITS > SIZE || ID < -1) begin : g_bad_params
        $error("fifo_rr_arbiter: invalid parameter set");
    end

    arb_state_e        state_r;
    arb_state_e        state_next_s;
    logic [N_LOG2-1:0] last_r;
    logic [N-1:0]      req_s;
    logic [N-1:0]      grant_s;
    logic [N_LOG2-1:0] sel_s;
    logic              any_s;
    logic              load_s;

    assign req_s = ~fifo_empty;

    rr_select #(
        .N      (N),
        .N_LOG2 (N_LOG2)
    ) u_rr_select (
        .req       (req_s),
        .last      (last_r),
        .grant     (grant_s),
        .grant_idx (sel_s),
        .any_req   (any_s)
    );

    // Load decision, pop strobe and next state; nothing pops while reset is high.
    always_comb begin
        load_s       = 1'b0;
        state_next_s = state_r;
        fifo_read    = '0;
        if (reset) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: load_s = any_s;
                ST_HOLD: load_s = out_ready & any_s;
                default: load_s = 1'b0;
            endcase
            if (load_s) begin
                fifo_read    = grant_s;
                state_next_s = ST_HOLD;
            end else if (state_r == ST_HOLD && out_ready) begin
                state_next_s = ST_IDLE;
            end else begin
                state_next_s = state_r;
            end
        end
    end

    // State, output channel registers and rotation pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            out_valid <= 1'b0;
            out_item  <= '0;
            out_src   <= '0;
            last_r    <= N_LOG2'(N - 1);
        end else begin
            state_r <= state_next_s;
            if (load_s) begin
                out_item  <= fifo_item[int'(sel_s) * SIZE +: SIZE];
                out_src   <= sel_s;
                last_r    <= sel_s;
                out_valid <= 1'b1;
            end else if (state_r == ST_HOLD && out_ready) begin
                out_valid <= 1'b0;
            end else begin
                out_valid <= out_valid;
            end
        end
    end

    // Completed-handshake counter, wrapping naturally at its width.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_count <= '0;
        end else if (out_valid && out_ready) begin
            tx_count <= tx_count + 16'd1;
        end else begin
            tx_count <= tx_count;
        end
    end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Self-checking bench for fifo_rr_arbiter: directed vector table, hand-written
// corner sequences, and randomized traffic against a queue-based reference.
module tb_fifo_rr_arbiter;

    localparam int N    = 4;
    localparam int SIZE = 8;
    localparam logic [N*SIZE-1:0] ITEMS = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    fifo_empty = '0;
    logic [N*SIZE-1:0] fifo_item = ITEMS;
    logic [N-1:0]    fifo_read;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [SIZE-1:0] out_item;
    logic [1:0]      out_src;
    logic [15:0]     tx_count;

    fifo_rr_arbiter #(.ID(0), .SIZE(SIZE), .N(N), .N_LOG2(2), .DESTINATION_BITS(4)) dut (
        .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_item(fifo_item),
        .fifo_read(fifo_read), .out_valid(out_valid), .out_ready(out_ready),
        .out_item(out_item), .out_src(out_src), .tx_count(tx_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [N-1:0] rd_seen;

    typedef struct {
        logic [N-1:0] emp;
        logic         rdy;
        logic [N-1:0] exp_rd;
        logic         exp_valid;
        logic [1:0]   exp_src;
        int           exp_tx;
    } vec_t;
    vec_t tbl[14];

    typedef logic [7:0] byte_q_t[$];
    byte_q_t fq[N];
    logic       m_valid;
    logic [7:0] m_item;
    int         m_src, m_last, m_tx;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_cycle(input logic rst, input logic [N-1:0] emp,
                               input logic [N*SIZE-1:0] items, input logic rdy);
        @(negedge clk);
        reset = rst; fifo_empty = emp; fifo_item = items; out_ready = rdy;
        #1;
        rd_seen = fifo_read;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_item = 8'h00; m_src = 0; m_last = N - 1; m_tx = 0;
    endtask

    // One cycle of queue-backed FIFOs checked against the reference model.
    task automatic env_cycle(input logic rdy);
        int sel;
        logic [7:0] head;
        logic [N-1:0] exp_rd;
        @(negedge clk);
        reset = 1'b0; out_ready = rdy;
        for (int i = 0; i < N; i++) begin
            fifo_empty[i] = (fq[i].size() == 0);
            fifo_item[i*SIZE +: SIZE] = (fq[i].size() > 0) ? fq[i][0] : 8'h00;
        end
        sel = -1;
        if (!m_valid || rdy) begin
            for (int k = 1; k <= N; k++) begin
                if (sel < 0 && fq[(m_last + k) % N].size() > 0) sel = (m_last + k) % N;
            end
        end
        exp_rd = '0;
        if (sel >= 0) exp_rd[sel] = 1'b1;
        #1;
        chk("fifo_read", fifo_read, exp_rd);
        rd_seen = fifo_read;
        head = (sel >= 0) ? fq[sel][0] : 8'h00;
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            if (rd_seen[i] && fq[i].size() > 0) void'(fq[i].pop_front());
        end
        if (m_valid && rdy) m_tx = (m_tx + 1) % 65536;
        if (sel >= 0) begin
            m_valid = 1'b1; m_item = head; m_src = sel; m_last = sel;
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        #1;
        chk("out_valid", out_valid, m_valid);
        chk("out_item", out_item, m_item);
        chk("out_src", out_src, m_src);
        chk("tx_count", tx_count, m_tx);
    endtask

    initial begin
        logic [N*SIZE-1:0] bp_items;

        // Fairness then skip/wrap, starting straight out of reset.
        for (int k = 0; k < 8; k++)
            tbl[k] = '{4'b0000, 1'b1, 4'(1 << (k % 4)), 1'b1, 2'(k % 4), k};
        tbl[8]  = '{4'b1111, 1'b1, 4'b0000, 1'b0, 2'd3, 8};
        tbl[9]  = '{4'b0101, 1'b1, 4'b0010, 1'b1, 2'd1, 8};
        tbl[10] = '{4'b0101, 1'b1, 4'b1000, 1'b1, 2'd3, 9};
        tbl[11] = '{4'b0101, 1'b1, 4'b0010, 1'b1, 2'd1, 10};
        tbl[12] = '{4'b0101, 1'b1, 4'b1000, 1'b1, 2'd3, 11};
        tbl[13] = '{4'b1111, 1'b1, 4'b0000, 1'b0, 2'd3, 12};

        // Reset held two cycles with every FIFO non-empty.
        for (int r = 0; r < 2; r++) begin
            drive_cycle(1'b1, 4'b0000, ITEMS, 1'b1);
            chk("reset_read", rd_seen, 4'b0000);
            chk("reset_valid", out_valid, 1'b0);
            chk("reset_item", out_item, 8'h00);
            chk("reset_src", out_src, 2'd0);
            chk("reset_tx", tx_count, 16'd0);
        end

        for (int v = 0; v < 14; v++) begin
            drive_cycle(1'b0, tbl[v].emp, ITEMS, tbl[v].rdy);
            chk($sformatf("tbl%0d_read", v), rd_seen, tbl[v].exp_rd);
            chk($sformatf("tbl%0d_valid", v), out_valid, tbl[v].exp_valid);
            chk($sformatf("tbl%0d_src", v), out_src, tbl[v].exp_src);
            chk($sformatf("tbl%0d_item", v), out_item, 8'hA0 + 8'(tbl[v].exp_src));
            chk($sformatf("tbl%0d_tx", v), tx_count, tbl[v].exp_tx);
        end

        // Backpressure: 0x5A loaded from FIFO 2, then held for 5 stalled cycles.
        bp_items = ITEMS;
        bp_items[2*SIZE +: SIZE] = 8'h5A;
        drive_cycle(1'b0, 4'b1011, bp_items, 1'b0);
        chk("bp_load_read", rd_seen, 4'b0100);
        chk("bp_load_item", out_item, 8'h5A);
        chk("bp_load_src", out_src, 2'd2);
        for (int s = 0; s < 5; s++) begin
            drive_cycle(1'b0, 4'b0000, ITEMS, 1'b0);
            chk("bp_read", rd_seen, 4'b0000);
            chk("bp_valid", out_valid, 1'b1);
            chk("bp_item", out_item, 8'h5A);
            chk("bp_tx", tx_count, 16'd12);
        end

        // Reset while holding with out_ready low.
        drive_cycle(1'b1, 4'b0000, ITEMS, 1'b0);
        chk("rst_hold_read", rd_seen, 4'b0000);
        chk("rst_hold_valid", out_valid, 1'b0);
        chk("rst_hold_item", out_item, 8'h00);
        chk("rst_hold_tx", tx_count, 16'd0);

        // Single-source streaming from FIFO 2.
        model_reset();
        fq[2].push_back(8'h11); fq[2].push_back(8'h22); fq[2].push_back(8'h33);
        for (int s = 0; s < 5; s++) env_cycle(1'b1);
        chk("stream_drained", fq[2].size(), 0);

        // Randomized traffic and backpressure.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(2, 0) != 0) begin
                int f;
                f = $urandom_range(N - 1, 0);
                if (fq[f].size() < 6) fq[f].push_back(8'($urandom));
            end
            env_cycle(1'($urandom_range(3, 0) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
